// File: rtl/decode_issue_pkg.sv
// Shared opcode constants, forwarding-source record and operand-use decode
// for the RV32 decode/issue stage.
package decode_issue_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic                valid;
        logic                pending;
        logic [4:0]          addr;
        logic [PKG_XLEN-1:0] data;
    } fwd_src_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Unknown opcodes write nothing, so they never claim an rd.
    function automatic logic has_rd(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_stage_operand_fwd_mux.sv
// Resolves one source operand against the forwarding sources; index 0 is the
// youngest writer and wins over every older match.
module operand_fwd_mux
    import decode_issue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]      i_addr,
    input  logic [XLEN-1:0] i_rf_data,
    input  fwd_src_t        i_srcs [NUM_FWD],
    output logic [XLEN-1:0] o_data,
    output logic            o_hit_pending
);

    // NOTE: every output gets a default before any conditional assignment,
    // otherwise synthesis infers latches for the paths that do not write it.
    always_comb begin
        o_data        = i_rf_data;
        o_hit_pending = 1'b0;
        if (i_addr == 5'd0) begin
            o_data = '0;
        end else begin
            // Walk oldest to youngest so the youngest match is written last.
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (i_srcs[i].valid && (i_srcs[i].addr == i_addr)) begin
                    o_data        = XLEN'(i_srcs[i].data);
                    o_hit_pending = i_srcs[i].pending;
                end
            end
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// In-order RV32 decode/issue stage: operand forwarding, load-use stall,
// valid/ready issue register with flush and a saturating stall counter.
module decode_issue_stage
    import decode_issue_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instruction_in,
    input  logic [XLEN-1:0]          program_counter_in,
    output logic [4:0]               rf_rs1_addr_out,
    output logic [4:0]               rf_rs2_addr_out,
    input  logic [XLEN-1:0]          rf_rs1_data_in,
    input  logic [XLEN-1:0]          rf_rs2_data_in,
    input  logic [NUM_FWD-1:0]       fwd_valid_in,
    input  logic [NUM_FWD-1:0]       fwd_pending_in,
    input  logic [NUM_FWD*5-1:0]     fwd_addr_in,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data_in,
    input  logic                     flush_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          rs1_data_reg_out,
    output logic [XLEN-1:0]          rs2_data_reg_out,
    output logic [XLEN-1:0]          program_counter_reg_out,
    output logic [31:0]              instruction_reg_out,
    output logic [4:0]               rd_addr_reg_out,
    output logic [STALL_CNT_W-1:0]   stall_count_out
);

    logic [6:0]       w_opcode;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_rs1_pending;
    logic             w_rs2_pending;
    logic             w_hazard;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_stall_evt;
    fwd_src_t         w_srcs [NUM_FWD];

    logic                    r_out_valid;
    logic [XLEN-1:0]         r_rs1_data;
    logic [XLEN-1:0]         r_rs2_data;
    logic [XLEN-1:0]         r_pc;
    logic [31:0]             r_instr;
    logic [4:0]              r_rd;
    logic [STALL_CNT_W-1:0]  r_stall_count;

    assign w_opcode        = instruction_in[6:0];
    assign rf_rs1_addr_out = instruction_in[19:15];
    assign rf_rs2_addr_out = instruction_in[24:20];
    assign w_use_rs1       = uses_rs1(w_opcode);
    assign w_use_rs2       = uses_rs2(w_opcode);

    for (genvar g = 0; g < NUM_FWD; g++) begin : g_src
        assign w_srcs[g] = '{
            valid:   fwd_valid_in[g],
            pending: fwd_pending_in[g],
            addr:    fwd_addr_in[g*5 +: 5],
            data:    PKG_XLEN'(fwd_data_in[g*XLEN +: XLEN])
        };
    end

    operand_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_rs1_mux (
        .i_addr        (rf_rs1_addr_out),
        .i_rf_data     (rf_rs1_data_in),
        .i_srcs        (w_srcs),
        .o_data        (w_rs1_data),
        .o_hit_pending (w_rs1_pending)
    );

    operand_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_rs2_mux (
        .i_addr        (rf_rs2_addr_out),
        .i_rf_data     (rf_rs2_data_in),
        .i_srcs        (w_srcs),
        .o_data        (w_rs2_data),
        .o_hit_pending (w_rs2_pending)
    );

    // A pending winner only matters for an operand the instruction actually reads.
    assign w_hazard    = in_valid && ((w_use_rs1 && w_rs1_pending) ||
                                      (w_use_rs2 && w_rs2_pending));
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !w_hazard && !flush_in && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_stall_evt = w_hazard && !flush_in;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_pc          <= '0;
            r_instr       <= '0;
            r_rd          <= '0;
            r_stall_count <= '0;
        end else begin
            if (flush_in) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_pc       <= program_counter_in;
                r_instr    <= instruction_in;
                r_rd       <= has_rd(w_opcode) ? instruction_in[11:7] : 5'd0;
            end

            if (w_stall_evt && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            end
        end
    end

    assign out_valid               = r_out_valid;
    assign rs1_data_reg_out        = r_rs1_data;
    assign rs2_data_reg_out        = r_rs2_data;
    assign program_counter_reg_out = r_pc;
    assign instruction_reg_out     = r_instr;
    assign rd_addr_reg_out         = r_rd;
    assign stall_count_out         = r_stall_count;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: forwarding priority, load-use stall,
// x0 handling, backpressure, flush, counter saturation and async reset.
module tb_decode_issue_stage;

    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam int SCW  = 4;

    localparam logic [31:0] I_ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] I_ADD_5_1_2 = 32'h002082B3;
    localparam logic [31:0] I_LUI_X1    = 32'h123450B7;
    localparam logic [31:0] I_ADDI_X0   = 32'h00500013;
    localparam logic [31:0] I_SW        = 32'h0020A2A3;
    localparam logic [31:0] I_CUSTOM    = 32'h0000818B;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instruction_in;
    logic [XLEN-1:0]    program_counter_in;
    logic [4:0]         rf_rs1_addr_out;
    logic [4:0]         rf_rs2_addr_out;
    logic [XLEN-1:0]    rf_rs1_data_in;
    logic [XLEN-1:0]    rf_rs2_data_in;
    logic [NF-1:0]      fwd_valid_in;
    logic [NF-1:0]      fwd_pending_in;
    logic [NF*5-1:0]    fwd_addr_in;
    logic [NF*XLEN-1:0] fwd_data_in;
    logic               flush_in;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    rs1_data_reg_out;
    logic [XLEN-1:0]    rs2_data_reg_out;
    logic [XLEN-1:0]    program_counter_reg_out;
    logic [31:0]        instruction_reg_out;
    logic [4:0]         rd_addr_reg_out;
    logic [SCW-1:0]     stall_count_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(
        .XLEN        (XLEN),
        .NUM_FWD     (NF),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .instruction_in          (instruction_in),
        .program_counter_in      (program_counter_in),
        .rf_rs1_addr_out         (rf_rs1_addr_out),
        .rf_rs2_addr_out         (rf_rs2_addr_out),
        .rf_rs1_data_in          (rf_rs1_data_in),
        .rf_rs2_data_in          (rf_rs2_data_in),
        .fwd_valid_in            (fwd_valid_in),
        .fwd_pending_in          (fwd_pending_in),
        .fwd_addr_in             (fwd_addr_in),
        .fwd_data_in             (fwd_data_in),
        .flush_in                (flush_in),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .rs1_data_reg_out        (rs1_data_reg_out),
        .rs2_data_reg_out        (rs2_data_reg_out),
        .program_counter_reg_out (program_counter_reg_out),
        .instruction_reg_out     (instruction_reg_out),
        .rd_addr_reg_out         (rd_addr_reg_out),
        .stall_count_out         (stall_count_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid_in   = '0;
        fwd_pending_in = '0;
        fwd_addr_in    = '0;
        fwd_data_in    = '0;
    endtask

    task automatic set_fwd(input int idx, input logic pend, input logic [4:0] addr,
                           input logic [31:0] data);
        fwd_valid_in[idx]          = 1'b1;
        fwd_pending_in[idx]        = pend;
        fwd_addr_in[idx*5 +: 5]    = addr;
        fwd_data_in[idx*32 +: 32]  = data;
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        in_valid           = 1'b0;
        instruction_in     = '0;
        program_counter_in = '0;
        rf_rs1_data_in     = '0;
        rf_rs2_data_in     = '0;
        flush_in           = 1'b0;
        out_ready          = 1'b1;
        clear_fwd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
        instruction_in = '0; program_counter_in = '0;
        rf_rs1_data_in = '0; rf_rs2_data_in = '0;
        clear_fwd();
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (stall_count_out !== 4'd0) begin n_errors++; $display("FAIL reset_stall: got %0d want 0", stall_count_out); end
        n_checks++;
        if ({rs1_data_reg_out, rs2_data_reg_out, program_counter_reg_out, instruction_reg_out, rd_addr_reg_out} !== '0) begin
            n_errors++;
            $display("FAIL reset_regs: rs1=%h rs2=%h pc=%h instr=%h rd=%0d want all 0",
                     rs1_data_reg_out, rs2_data_reg_out, program_counter_reg_out, instruction_reg_out, rd_addr_reg_out);
        end
        do_reset();
    endtask

    task automatic test_basic_add();
        do_reset();
        instruction_in = I_ADD_3_1_2; program_counter_in = 32'h0000_0100;
        rf_rs1_data_in = 32'd5; rf_rs2_data_in = 32'd7; in_valid = 1'b1;
        #1;
        n_checks++;
        if ({rf_rs1_addr_out, rf_rs2_addr_out} !== {5'd1, 5'd2}) begin
            n_errors++; $display("FAIL rf_addr: got %0d/%0d want 1/2", rf_rs1_addr_out, rf_rs2_addr_out);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_latency: got %b want 0 before edge", out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_checks++;
        if ({rs1_data_reg_out, rs2_data_reg_out} !== {32'd5, 32'd7}) begin
            n_errors++; $display("FAIL basic_operands: got %h/%h want 5/7", rs1_data_reg_out, rs2_data_reg_out);
        end
        n_checks++;
        if ({rd_addr_reg_out, program_counter_reg_out, instruction_reg_out} !== {5'd3, 32'h100, I_ADD_3_1_2}) begin
            n_errors++; $display("FAIL basic_bundle: rd=%0d pc=%h instr=%h want 3/100/%h",
                                 rd_addr_reg_out, program_counter_reg_out, instruction_reg_out, I_ADD_3_1_2);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        instruction_in = I_ADD_3_1_2; rf_rs1_data_in = 32'h1; rf_rs2_data_in = 32'h7;
        set_fwd(0, 1'b0, 5'd1, 32'hAAAA);
        set_fwd(2, 1'b0, 5'd1, 32'hBBBB);
        in_valid = 1'b1;
        tick();
        n_checks++;
        if ({rs1_data_reg_out, rs2_data_reg_out} !== {32'hAAAA, 32'h7}) begin
            n_errors++; $display("FAIL fwd_youngest: got %h/%h want aaaa/7", rs1_data_reg_out, rs2_data_reg_out);
        end
        clear_fwd();
        set_fwd(2, 1'b0, 5'd1, 32'hBBBB);
        set_fwd(1, 1'b0, 5'd2, 32'hCCCC);
        tick();
        n_checks++;
        if ({rs1_data_reg_out, rs2_data_reg_out} !== {32'hBBBB, 32'hCCCC}) begin
            n_errors++; $display("FAIL fwd_per_operand: got %h/%h want bbbb/cccc", rs1_data_reg_out, rs2_data_reg_out);
        end
        // Older pending match is shadowed by a younger ready one: no stall.
        clear_fwd();
        set_fwd(0, 1'b0, 5'd1, 32'h1111);
        set_fwd(1, 1'b1, 5'd1, 32'h2222);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fwd_shadow_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (rs1_data_reg_out !== 32'h1111) begin
            n_errors++; $display("FAIL fwd_shadow_data: got %h want 1111", rs1_data_reg_out);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instruction_in = I_ADD_3_1_2; rf_rs1_data_in = 32'h1; rf_rs2_data_in = 32'h2;
        set_fwd(0, 1'b1, 5'd1, 32'h77);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL lu_in_ready_c%0d: got %b want 0", c, in_ready); end
            tick();
        end
        n_checks++;
        if ({out_valid, stall_count_out} !== {1'b0, 4'd3}) begin
            n_errors++; $display("FAIL lu_stall: valid=%b count=%0d want 0/3", out_valid, stall_count_out);
        end
        set_fwd(0, 1'b0, 5'd1, 32'h99);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL lu_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, rs1_data_reg_out, stall_count_out} !== {1'b1, 32'h99, 4'd3}) begin
            n_errors++; $display("FAIL lu_issue: valid=%b rs1=%h count=%0d want 1/99/3",
                                 out_valid, rs1_data_reg_out, stall_count_out);
        end
    endtask

    task automatic test_no_rs_and_x0();
        do_reset();
        instruction_in = I_LUI_X1;
        set_fwd(0, 1'b1, 5'd1, 32'h33);
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL lui_no_stall: got %b want 1", in_ready); end
        tick();
        n_checks++;
        if ({out_valid, rd_addr_reg_out} !== {1'b1, 5'd1}) begin
            n_errors++; $display("FAIL lui_issue: valid=%b rd=%0d want 1/1", out_valid, rd_addr_reg_out);
        end
        clear_fwd();
        set_fwd(0, 1'b1, 5'd0, 32'h55);
        instruction_in = I_ADDI_X0; rf_rs1_data_in = 32'h1234;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL x0_no_stall: got %b want 1", in_ready); end
        tick();
        n_checks++;
        if ({rs1_data_reg_out, rd_addr_reg_out} !== {32'h0, 5'd0}) begin
            n_errors++; $display("FAIL x0_value: rs1=%h rd=%0d want 0/0", rs1_data_reg_out, rd_addr_reg_out);
        end
        clear_fwd();
        instruction_in = I_SW;
        tick();
        n_checks++;
        if ({out_valid, rd_addr_reg_out, instruction_reg_out} !== {1'b1, 5'd0, I_SW}) begin
            n_errors++; $display("FAIL store_no_rd: valid=%b rd=%0d instr=%h want 1/0/%h",
                                 out_valid, rd_addr_reg_out, instruction_reg_out, I_SW);
        end
        set_fwd(0, 1'b1, 5'd1, 32'h44);
        instruction_in = I_CUSTOM;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL custom_no_stall: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({rd_addr_reg_out, stall_count_out} !== {5'd0, 4'd0}) begin
            n_errors++; $display("FAIL custom_no_rd: rd=%0d count=%0d want 0/0", rd_addr_reg_out, stall_count_out);
        end
    endtask

    task automatic test_backpressure_flush();
        do_reset();
        instruction_in = I_ADD_3_1_2; program_counter_in = 32'h200;
        rf_rs1_data_in = 32'd5; rf_rs2_data_in = 32'd7; in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        instruction_in = I_ADD_5_1_2; program_counter_in = 32'h204;
        rf_rs1_data_in = 32'h10; rf_rs2_data_in = 32'h20;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
            n_checks++;
            if ({out_valid, rs1_data_reg_out, rs2_data_reg_out, rd_addr_reg_out, program_counter_reg_out} !==
                {1'b1, 32'd5, 32'd7, 5'd3, 32'h200}) begin
                n_errors++; $display("FAIL bp_hold_c%0d: valid=%b rs1=%h rs2=%h rd=%0d pc=%h want 1/5/7/3/200",
                                     c, out_valid, rs1_data_reg_out, rs2_data_reg_out, rd_addr_reg_out, program_counter_reg_out);
            end
            tick();
        end
        flush_in = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush_in = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_clear: got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, rs1_data_reg_out, rd_addr_reg_out} !== {1'b1, 32'h10, 5'd5}) begin
            n_errors++; $display("FAIL post_flush_issue: valid=%b rs1=%h rd=%0d want 1/10/5",
                                 out_valid, rs1_data_reg_out, rd_addr_reg_out);
        end
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        instruction_in = I_ADD_3_1_2; rf_rs1_data_in = 32'd5; rf_rs2_data_in = 32'd7;
        set_fwd(0, 1'b1, 5'd1, 32'h0);
        in_valid = 1'b1; flush_in = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (stall_count_out !== 4'd0) begin n_errors++; $display("FAIL flush_no_count: got %0d want 0", stall_count_out); end
        flush_in = 1'b0;
        clear_fwd();
        tick();
        out_ready = 1'b0;
        set_fwd(0, 1'b1, 5'd1, 32'h0);
        repeat (14) tick();
        n_checks++;
        if (stall_count_out !== 4'd14) begin n_errors++; $display("FAIL sat_pre: got %0d want 14", stall_count_out); end
        repeat (6) tick();
        n_checks++;
        if (stall_count_out !== 4'd15) begin n_errors++; $display("FAIL sat_hold: got %0d want 15", stall_count_out); end
        n_checks++;
        if ({out_valid, rs1_data_reg_out} !== {1'b1, 32'd5}) begin
            n_errors++; $display("FAIL sat_bundle: valid=%b rs1=%h want 1/5", out_valid, rs1_data_reg_out);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, stall_count_out, rs1_data_reg_out, rs2_data_reg_out, program_counter_reg_out,
             instruction_reg_out, rd_addr_reg_out} !== '0) begin
            n_errors++; $display("FAIL async_reset: valid=%b count=%0d rs1=%h instr=%h rd=%0d want all 0",
                                 out_valid, stall_count_out, rs1_data_reg_out, instruction_reg_out, rd_addr_reg_out);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_fwd_priority();
        test_load_use();
        test_no_rs_and_x0();
        test_backpressure_flush();
        test_saturation_and_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Parametrised decode/issue stage for the in-order RV32 pipeline; sits between fetch and execute.
- Reads operands from the external register file and resolves them against NUM_FWD forwarding sources in priority order.
- Detects load-use hazards and stalls through a valid/ready handshake. Registers the issued bundle for execute.
- Generalises the fixed three-source decode stage with a configurable source count, a backpressure handshake, flush support and a stall counter.

Parameters:
- XLEN, 32, data and PC width
- NUM_FWD, 3, forwarding sources; index 0 is the youngest and highest priority
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  stage accepts bundle this cycle
- instruction_in  in  32  raw instruction
- program_counter_in  in  XLEN  PC of instruction_in
- rf_rs1_addr_out  out  5  instruction_in[19:15], combinational
- rf_rs2_addr_out  out  5  instruction_in[24:20], combinational
- rf_rs1_data_in  in  XLEN  async register-file read data
- rf_rs2_data_in  in  XLEN  async register-file read data
- fwd_valid_in  in  NUM_FWD  source i holds a register write
- fwd_pending_in  in  NUM_FWD  source i's data is not yet available (load in flight)
- fwd_addr_in  in  NUM_FWD*5  destination register of source i
- fwd_data_in  in  NUM_FWD*XLEN  write data of source i
- flush_in  in  1  squash the held and incoming bundle
- out_valid  out  1  issued bundle valid
- out_ready  in  1  execute accepts bundle
- rs1_data_reg_out  out  XLEN  resolved rs1
- rs2_data_reg_out  out  XLEN  resolved rs2
- program_counter_reg_out  out  XLEN  registered PC
- instruction_reg_out  out  32  registered instruction
- rd_addr_reg_out  out  5  registered rd (0 if the instruction has no rd)
- stall_count_out  out  STALL_CNT_W  hazard-stall cycles, saturating

Behaviour:
- Reset: every registered output and stall_count_out = 0; out_valid = 0.
- Use decode, from opcode [6:0]:
  - LUI, AUIPC, JAL: no rs.
  - JALR, LOAD, OP-IMM: rs1 only.
  - OP, STORE, BRANCH: rs1 and rs2.
  - Any other opcode: no rs, no rd.
  - STORE and BRANCH have no rd.
- Per operand resolution:
  - addr = 0 gives 0.
  - Otherwise the lowest index i with fwd_valid_in[i] && fwd_addr_in[i] == addr && addr != 0 wins.
  - If no source matches, use rf data.
  - Only the winning source is consulted; older matches are ignored.
- hazard = in_valid && (an operand the instruction uses has a winning source with fwd_pending_in set).
- accept = in_valid && !hazard && !flush_in && (!out_valid || out_ready).
- in_ready = !hazard && !flush_in && (!out_valid || out_ready). It is combinational, with no register in the ready path.
- Latency: 1 cycle. On accept, the output registers load the resolved bundle and out_valid = 1 in the next cycle.
- When not accepting:
  - out_ready = 1 clears out_valid.
  - Otherwise the bundle holds stable; execute sees no change while stalled.
- flush_in = 1: out_valid = 0 next cycle and no accept. Flush has priority over every other event.
- Data registers:
  - They update only on accept.
  - While out_valid = 0 their values are don't-care for the bench but must not be X after reset.
- stall_count_out increments when in_valid && hazard && !flush_in. It saturates at all-ones and never wraps.
- Reset asserted mid-stall: outputs clear immediately (asynchronous); the counter returns to 0.

Decomposition:
- decode_issue_pkg:
  - opcode localparams.
  - fwd_src_t struct {valid, pending, addr[4:0], data[XLEN-1:0]}.
  - functions uses_rs1, uses_rs2, has_rd.
- Sub-module operand_fwd_mux, instantiated twice:
  - Combinational priority resolve of one operand over NUM_FWD sources.
  - Outputs: data, hit_pending.

Test Plan:
- Reset, then ADD x3,x1,x2 with rf x1=5, x2=7, no fwd, out_ready=1 -> next cycle out_valid=1, rs1=5, rs2=7, rd=3.
- fwd0 = {x1, 0xAAAA}, fwd2 = {x1, 0xBBBB}, rf x1=0x1 -> rs1_data_reg_out=0xAAAA; priority goes to the youngest.
- fwd_pending_in[0] with addr x1, ADD reads x1, held 3 cycles -> in_ready=0 for 3 cycles, stall_count_out=3; after pending drops the bundle issues with the forwarded value.
- LUI x1 with pending fwd on x1; ADDI x0 source x0 with fwd {x0, 0x55} -> no stall; x0 resolves to 0.
- out_ready=0 for 4 cycles with out_valid=1 -> outputs stable, in_ready=0; flush_in pulse -> out_valid=0 next cycle.
- STALL_CNT_W=4, hazard held 20 cycles -> stall_count_out saturates at 15; rst low mid-stall -> all outputs 0 asynchronously.
